mmio_console: RTL

Memory-mapped console peripheral that sits on the CPU data-memory port in the address window at or above `32'hFFFF0000`, which the top-level address decoder steers away from data memory, and on the PDU's byte-stream interface. It buffers CPU-to-PDU output bytes and PDU-to-CPU input bytes in two independent FIFOs. It exposes status and overflow flags and an 8-bit LED register. The CPU polls status registers; the PDU drains and fills the FIFOs with valid/ready handshakes.

---
 rtl/mmio_console_if.sv | 24 ++
 rtl/mmio_console.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mmio_console_if.sv
// CPU data-port and PDU byte-stream signals of the memory-mapped console.
// Handshakes: TX byte moves on a cycle with tx_valid && tx_accept; RX byte moves on a cycle with rx_valid && rx_ready.
interface mmio_console_if;
    logic [31:0] cpu_addr;
    logic        cpu_we;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_accept;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;

    modport slave (
        input  cpu_addr, cpu_we, cpu_wdata, tx_accept, rx_valid, rx_data,
        output cpu_rdata, tx_valid, tx_data, rx_ready
    );

    modport master (
        output cpu_addr, cpu_we, cpu_wdata, tx_accept, rx_valid, rx_data,
        input  cpu_rdata, tx_valid, tx_data, rx_ready
    );
endinterface

// File: rtl/mmio_console.sv
// Console peripheral: TX and RX byte FIFOs with sticky overflow flags plus an LED register,
// polled by the CPU through a small register window.
module mmio_console #(
    parameter int          DEPTH = 8,
    parameter logic [31:0] BASE  = 32'hFFFF0000
) (
    input  logic             clk,
    input  logic             rst,
    mmio_console_if.slave    bus,
    output logic [7:0]       led
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    // Registers occupy only the first 32 bytes of the window; higher offsets are unmapped.
    logic       sel;
    logic [2:0] off;
    assign sel = (bus.cpu_addr[31:16] == BASE[31:16]) && (bus.cpu_addr[15:5] == 11'd0);
    assign off = bus.cpu_addr[4:2];

    logic unused_bits;
    assign unused_bits = ^{bus.cpu_addr[1:0], bus.cpu_wdata[31:8]};

    logic wr_txdata, wr_txstat, wr_rxpop, wr_rxstat, wr_led;
    assign wr_txdata = bus.cpu_we && sel && (off == 3'd0);
    assign wr_txstat = bus.cpu_we && sel && (off == 3'd1);
    assign wr_rxpop  = bus.cpu_we && sel && (off == 3'd3);
    assign wr_rxstat = bus.cpu_we && sel && (off == 3'd4);
    assign wr_led    = bus.cpu_we && sel && (off == 3'd5);

    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wp, tx_rp;
    logic [CW-1:0] tx_cnt;
    logic          tx_ovf, tx_full, tx_empty, tx_push, tx_pop;

    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wp, rx_rp;
    logic [CW-1:0] rx_cnt;
    logic          rx_ovf, rx_full, rx_empty, rx_push, rx_pop;

    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign tx_push  = wr_txdata && !tx_full;
    assign tx_pop   = !tx_empty && bus.tx_accept;

    assign rx_full  = (rx_cnt == FULL_CNT);
    assign rx_empty = (rx_cnt == '0);
    assign rx_push  = bus.rx_valid && !rx_full;
    assign rx_pop   = wr_rxpop && !rx_empty;

    assign bus.tx_valid = !tx_empty;
    assign bus.tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rp];
    assign bus.rx_ready = !rx_full;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= bus.cpu_wdata[7:0];
        if (rx_push) rx_mem[rx_wp] <= bus.rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            tx_ovf <= 1'b0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + CNT_ONE;
                2'b01:   tx_cnt <= tx_cnt - CNT_ONE;
                default: tx_cnt <= tx_cnt;
            endcase
            // A write to a full FIFO is lost even if the PDU drains a byte in the same cycle.
            if (wr_txdata && tx_full) tx_ovf <= 1'b1;
            else if (wr_txstat)       tx_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
            rx_ovf <= 1'b0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + CNT_ONE;
                2'b01:   rx_cnt <= rx_cnt - CNT_ONE;
                default: rx_cnt <= rx_cnt;
            endcase
            // Set wins over clear so an overflow in the clearing cycle is not missed.
            if (bus.rx_valid && rx_full) rx_ovf <= 1'b1;
            else if (wr_rxstat)          rx_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         led <= 8'h00;
        else if (wr_led) led <= bus.cpu_wdata[7:0];
    end

    logic [7:0] rx_head;
    assign rx_head = rx_empty ? 8'h00 : rx_mem[rx_rp];

    always_comb begin
        bus.cpu_rdata = 32'h0;
        if (sel) begin
            case (off)
                3'd1:    bus.cpu_rdata = {16'b0, 8'(tx_cnt), 5'b0, tx_ovf, tx_empty, tx_full};
                3'd2:    bus.cpu_rdata = {!rx_empty, 23'b0, rx_head};
                3'd4:    bus.cpu_rdata = {16'b0, 8'(rx_cnt), 5'b0, rx_ovf, rx_empty, rx_full};
                3'd5:    bus.cpu_rdata = {24'b0, led};
                default: bus.cpu_rdata = 32'h0;
            endcase
        end
    end
endmodule
